// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access stage. Takes load/store strobes and the funct3 width code
// from the decoder, plus the ALU address and rs2 data, and turns them into a
// single byte-lane-aligned memory transaction. Loads return a sign- or
// zero-extended result. Misaligned, illegal and timed-out accesses end in an
// error pulse instead of a done pulse.
//
// Handshake: mem_req is raised with mem_we/mem_addr/mem_be/mem_wdata and all
// five stay constant until the memory answers with mem_ack (one cycle, read
// data valid in the same cycle) or until TIMEOUT request cycles pass. mem_ack
// is ignored whenever mem_req is low.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   ld_req, st_req      instruction is a load / store
//   funct3              width code (bit 2 = unsigned for loads)
//   addr, st_data       byte address and rs2 store data
//   stall               hold PC/register file (combinational)
//   done, err           one-cycle completion / abort pulses
//   err_code            01 misaligned, 10 timeout, 11 illegal; valid with err
//   ld_data             extended load result, held until the next load
//   mem_*               memory request side
//   fsm_state           current FSM state for debug/checkers
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  fsm_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          is_load;

  logic          req_any;
  logic          illegal;
  logic          misaligned;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   sel;
  logic [31:0]   ld_ext;

  assign fsm_state = state;
  assign req_any   = ld_req | st_req;
  assign stall     = (state == REQ) || ((state == IDLE) && req_any);

  // Illegal takes priority over misaligned, so funct3[1:0] below only ever
  // sees legal widths when it matters.
  always_comb begin
    illegal = (ld_req && st_req) ||
              (ld_req && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) ||
              (st_req && (funct3 >= 3'b011));
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Store data is replicated across lanes so the enabled lane always carries it.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = st_data;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{st_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = st_data;
      end
    endcase
  end

  // Load extraction uses the width/offset latched at request time.
  always_comb begin
    sel    = mem_rdata >> {off_q, 3'b000};
    ld_ext = sel;
    case (f3_q)
      3'b000:  ld_ext = {{24{sel[7]}}, sel[7:0]};
      3'b100:  ld_ext = {24'h0, sel[7:0]};
      3'b001:  ld_ext = {{16{sel[15]}}, sel[15:0]};
      3'b101:  ld_ext = {16'h0, sel[15:0]};
      default: ld_ext = sel;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      is_load   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ld_data   <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (illegal) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= 2'b11;
            end else if (misaligned) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= st_req;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              is_load   <= ld_req;
              wait_cnt  <= '0;
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack in the final allowed cycle wins.
          if (mem_ack) begin
            if (is_load) ld_data <= ld_ext;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          err_code <= 2'b00;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ld_req = 1'b0;
  logic        st_req = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        stall;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] ld_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .ld_req(ld_req), .st_req(st_req), .funct3(funct3),
    .addr(addr), .st_data(st_data), .stall(stall), .done(done), .err(err),
    .err_code(err_code), .ld_data(ld_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fsm_state(fsm_state)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request in an IDLE cycle, confirm combinational stall, then
  // clock it in and drop the request inputs.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
    ld_req = ld; st_req = st; funct3 = f3; addr = a; st_data = d;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    chk({tag, "_noreq_c0"}, 32'(mem_req), 32'd0);
    tick();
    ld_req = 1'b0; st_req = 1'b0;
  endtask

  // Check the error cycle that follows a rejected or timed-out request.
  task automatic err_cycle(input logic [1:0] code, input logic [31:0] ld_exp, input string tag);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_code"}, 32'(err_code), 32'(code));
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_lddata"}, ld_data, ld_exp);
    tick();
    chk({tag, "_err_off"}, 32'(err), 32'd0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_lddata", ld_data, 32'h0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'h0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // LB 0x103, ack on first REQ cycle
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, "lb");
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
    #1;
    chk("lb_memreq", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_be", 32'(mem_be), 32'h8);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_stall_c1", 32'(stall), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_stall_c2", 32'(stall), 32'd0);
    chk("lb_memreq_off", 32'(mem_req), 32'd0);
    chk("lb_lddata", ld_data, 32'hFFFF_FF80);
    tick();
    chk("lb_done_off", 32'(done), 32'd0);

    // LBU same access, issued in the IDLE cycle right after DONE
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, "lbu");
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("lbu_done", 32'(done), 32'd1);
    chk("lbu_lddata", ld_data, 32'h0000_0080);
    tick();

    // SH 0x202, ack after 3 wait cycles (4th REQ cycle = last allowed)
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, "sh");
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      mem_rdata = 32'h5555_5555;
      #1;
      chk("sh_memreq", 32'(mem_req), 32'd1);
      chk("sh_stall", 32'(stall), 32'd1);
      chk("sh_we", 32'(mem_we), 32'd1);
      chk("sh_addr", mem_addr, 32'h200);
      chk("sh_be", 32'(mem_be), 32'hC);
      chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      tick();
    end
    mem_ack = 1'b0;
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_err", 32'(err), 32'd0);
    chk("sh_stall_off", 32'(stall), 32'd0);
    chk("sh_lddata_kept", ld_data, 32'h0000_0080);
    tick();

    // LW 0x301 and LH 0x301: misaligned
    issue(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, "lw_mis");
    err_cycle(2'b01, 32'h0000_0080, "lw_mis");
    issue(1'b1, 1'b0, 3'b001, 32'h301, 32'h0, "lh_mis");
    err_cycle(2'b01, 32'h0000_0080, "lh_mis");

    // SW timeout: mem_req exactly 4 cycles, then err code 10
    issue(1'b0, 1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, "sw_to");
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sw_to_memreq", 32'(mem_req), 32'd1);
      chk("sw_to_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_to_be", 32'(mem_be), 32'hF);
      tick();
    end
    err_cycle(2'b10, 32'h0000_0080, "sw_to");

    // SW with ack in 4th cycle: done, no err
    issue(1'b0, 1'b1, 3'b010, 32'h404, 32'h0102_0304, "sw_late");
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      tick();
    end
    mem_ack = 1'b0;
    chk("sw_late_done", 32'(done), 32'd1);
    chk("sw_late_err", 32'(err), 32'd0);
    tick();

    // illegal: load funct3 011, then ld_req & st_req together
    issue(1'b1, 1'b0, 3'b011, 32'h500, 32'h0, "ld_f3");
    err_cycle(2'b11, 32'h0000_0080, "ld_f3");
    issue(1'b1, 1'b1, 3'b010, 32'h500, 32'h0, "ldst");
    err_cycle(2'b11, 32'h0000_0080, "ldst");
    // store funct3 011 is also illegal
    issue(1'b0, 1'b1, 3'b011, 32'h500, 32'h0, "st_f3");
    err_cycle(2'b11, 32'h0000_0080, "st_f3");

    // reset in the 2nd REQ cycle of an LW
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, "rst_mid");
    tick();
    #1;
    chk("rst_mid_memreq_pre", 32'(mem_req), 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid_memreq", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_lddata", ld_data, 32'h0);
    chk("rst_mid_state", 32'(fsm_state), 32'd0);
    tick();
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    RST = 1'b0;
    tick();
    chk("rst_mid_done2", 32'(done), 32'd0);
    chk("rst_mid_err2", 32'(err), 32'd0);

    // LH 0x102 signed after reset: upper half 0x8001 -> 0xFFFF8001
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, "lh_post");
    mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
    #1;
    chk("lh_post_be", 32'(mem_be), 32'hC);
    tick();
    mem_ack = 1'b0;
    chk("lh_post_done", 32'(done), 32'd1);
    chk("lh_post_lddata", ld_data, 32'hFFFF_8001);
    tick();

    // SB 0x001: byte replicated, lane 1
    issue(1'b0, 1'b1, 3'b000, 32'h001, 32'hFFFF_FF5A, "sb");
    #1;
    chk("sb_be", 32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", mem_addr, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_lddata_kept", ld_data, 32'hFFFF_8001);
    tick();

    // stray ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_done", 32'(done), 32'd0);
    chk("idle_ack_memreq", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
